// File: rtl/game_score_tracker.sv
// Game-progress controller: turns paddle-hit / ball-miss levels into a decimal
// score and lives count, sequences idle/play/respawn/game-over/win, freezes the ball.
module game_score_tracker #(
   parameter int MAX_SCORE      = 9,
   parameter int START_LIVES    = 3,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       hit,
   input  logic       miss,
   input  logic       frame_tick,
   output logic [3:0] score,
   output logic [1:0] lives,
   output logic       ball_freeze,
   output logic       game_over,
   output logic       game_win,
   output logic       life_lost
);

   localparam logic [3:0] SCORE_MAX    = 4'(MAX_SCORE);
   localparam logic [1:0] LIVES_INIT   = 2'(START_LIVES);
   localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PLAY     = 3'd1,
      S_RESPAWN  = 3'd2,
      S_GAMEOVER = 3'd3,
      S_WIN      = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] score_q, score_d;
   logic [1:0] lives_q, lives_d;
   logic [7:0] cnt_q, cnt_d;
   logic       life_lost_q, life_lost_d;

   logic start_q, hit_q, miss_q;
   logic start_block_q;
   logic start_ev, hit_ev, miss_ev;

   // start_block_q stops a start level held across reset release from
   // counting as a fresh press; it clears once start is seen low.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_q       <= 1'b0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         start_block_q <= start;
      end else begin
         start_q <= start;
         hit_q   <= hit;
         miss_q  <= miss;
         if (!start) begin
            start_block_q <= 1'b0;
         end
      end
   end

   assign start_ev = start & ~start_q & ~start_block_q;
   assign hit_ev   = hit & ~hit_q;
   assign miss_ev  = miss & ~miss_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         score_q     <= 4'd0;
         lives_q     <= LIVES_INIT;
         cnt_q       <= 8'd0;
         life_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         cnt_q       <= cnt_d;
         life_lost_q <= life_lost_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      lives_d     = lives_q;
      cnt_d       = cnt_q;
      life_lost_d = 1'b0;
      case (state_q)
         S_IDLE, S_GAMEOVER, S_WIN: begin
            if (start_ev) begin
               score_d = 4'd0;
               lives_d = LIVES_INIT;
               cnt_d   = 8'd0;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            // A miss wins over a simultaneous hit.
            if (miss_ev) begin
               life_lost_d = 1'b1;
               if (lives_q != 2'd0) begin
                  lives_d = lives_q - 2'd1;
               end
               if (lives_q <= 2'd1) begin
                  state_d = S_GAMEOVER;
               end else begin
                  state_d = S_RESPAWN;
                  cnt_d   = 8'd0;
               end
            end else if (hit_ev && (score_q < SCORE_MAX)) begin
               score_d = score_q + 4'd1;
               if (score_q + 4'd1 == SCORE_MAX) begin
                  state_d = S_WIN;
               end
            end
         end
         S_RESPAWN: begin
            if (frame_tick) begin
               if (cnt_q == RESPAWN_LAST) begin
                  cnt_d   = 8'd0;
                  state_d = S_PLAY;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign score       = score_q;
   assign lives       = lives_q;
   assign life_lost   = life_lost_q;
   assign ball_freeze = (state_q != S_PLAY);
   assign game_over   = (state_q == S_GAMEOVER);
   assign game_win    = (state_q == S_WIN);

endmodule

// File: tb/tb_game_score_tracker.sv
// Bench for game_score_tracker: directed game scenarios followed by random play,
// checked every cycle against a rule-level model through an expected-output queue.
module tb_game_score_tracker;

   localparam int MAX_SCORE      = 9;
   localparam int START_LIVES    = 3;
   localparam int RESPAWN_FRAMES = 60;

   logic       clk = 1'b0;
   logic       reset, start, hit, miss, frame_tick;
   logic [3:0] score;
   logic [1:0] lives;
   logic       ball_freeze, game_over, game_win, life_lost;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // {score[3:0], lives[1:0], ball_freeze, game_over, game_win, life_lost}
   logic [9:0] exp_q[$];

   game_score_tracker #(
      .MAX_SCORE(MAX_SCORE), .START_LIVES(START_LIVES), .RESPAWN_FRAMES(RESPAWN_FRAMES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .hit(hit), .miss(miss),
      .frame_tick(frame_tick), .score(score), .lives(lives),
      .ball_freeze(ball_freeze), .game_over(game_over), .game_win(game_win),
      .life_lost(life_lost)
   );

   always #5 clk = ~clk;

   // Reference model: game mode, score, lives and frames left in the pause.
   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3, M_WIN = 4;
   int m_mode = M_IDLE;
   int m_score = 0, m_lives = START_LIVES, m_left = 0, m_lost = 0;
   bit p_start = 0, p_hit = 0, p_miss = 0, m_blocked = 0;

   function void model_step(bit r, bit s, bit h, bit m, bit t);
      bit s_ev, h_ev, m_ev;
      if (r) begin
         m_mode = M_IDLE; m_score = 0; m_lives = START_LIVES; m_left = 0; m_lost = 0;
         p_start = 0; p_hit = 0; p_miss = 0; m_blocked = s;
      end else begin
         s_ev = s && !p_start && !m_blocked;
         h_ev = h && !p_hit;
         m_ev = m && !p_miss;
         p_start = s; p_hit = h; p_miss = m;
         if (!s) m_blocked = 0;
         m_lost = 0;
         if (m_mode == M_PLAY) begin
            if (m_ev) begin
               m_lost  = 1;
               m_lives = m_lives - 1;
               if (m_lives == 0) m_mode = M_OVER;
               else begin
                  m_mode = M_PAUSE;
                  m_left = RESPAWN_FRAMES;
               end
            end else if (h_ev) begin
               m_score = m_score + 1;
               if (m_score == MAX_SCORE) m_mode = M_WIN;
            end
         end else if (m_mode == M_PAUSE) begin
            if (t) begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = M_PLAY;
            end
         end else if (s_ev) begin
            m_mode = M_PLAY; m_score = 0; m_lives = START_LIVES;
         end
      end
      exp_q.push_back({4'(m_score), 2'(m_lives), 1'(m_mode != M_PLAY),
                       1'(m_mode == M_OVER), 1'(m_mode == M_WIN), 1'(m_lost)});
   endfunction

   // Inputs change on the falling edge; the expected state after the next
   // rising edge is queued at the same moment.
   task automatic step(input bit r, input bit s, input bit h, input bit m, input bit t);
      @(negedge clk);
      reset = r; start = s; hit = h; miss = m; frame_tick = t;
      model_step(r, s, h, m, t);
   endtask

   task automatic repeat_step(input int n, input bit s, input bit h, input bit m, input bit t);
      for (int i = 0; i < n; i++) step(0, s, h, m, t);
   endtask

   task automatic pulse_hit();
      repeat_step(2, 0, 1, 0, 0);
      repeat_step(2, 0, 0, 0, 0);
   endtask

   task automatic pulse_miss();
      repeat_step(2, 0, 0, 1, 0);
      repeat_step(2, 0, 0, 0, 0);
   endtask

   task automatic pulse_start();
      repeat_step(2, 1, 0, 0, 0);
      repeat_step(2, 0, 0, 0, 0);
   endtask

   // Monitor: one DUT output sample per rising edge against the queue head.
   initial begin
      logic [9:0] e, g;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {score, lives, ball_freeze, game_over, game_win, life_lost};
            checks++;
            if (g !== e) begin
               failures++;
               $display("FAIL outputs cycle=%0d got score=%0d lives=%0d frz=%0b over=%0b win=%0b lost=%0b exp score=%0d lives=%0d frz=%0b over=%0b win=%0b lost=%0b",
                        cyc, g[9:6], g[5:4], g[3], g[2], g[1], g[0],
                        e[9:6], e[5:4], e[3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      bit s, h, m;
      reset = 1; start = 0; hit = 0; miss = 0; frame_tick = 0;

      // Reset, idle with hit/miss ignored, then start.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      repeat_step(2, 0, 0, 0, 0);
      pulse_hit();
      pulse_miss();
      pulse_start();

      // Held hit counts once; re-raise counts again.
      repeat_step(20, 0, 1, 0, 0);
      repeat_step(3, 0, 0, 0, 0);
      repeat_step(3, 0, 1, 0, 0);
      repeat_step(2, 0, 0, 0, 0);

      // Miss, hit during respawn ignored, exactly RESPAWN_FRAMES ticks.
      repeat_step(4, 0, 0, 1, 0);
      repeat_step(3, 0, 1, 0, 0);
      repeat_step(2, 0, 0, 0, 0);
      repeat_step(RESPAWN_FRAMES, 0, 0, 0, 1);
      repeat_step(2, 0, 0, 0, 0);

      // Two more misses to game over; further events inert; restart.
      pulse_miss();
      repeat_step(RESPAWN_FRAMES, 0, 0, 0, 1);
      pulse_miss();
      pulse_hit();
      pulse_miss();
      pulse_start();

      // Ten hits: win at MAX_SCORE, tenth ignored; restart from win.
      for (int i = 0; i < 10; i++) pulse_hit();
      pulse_start();

      // Reach score 4 / lives 2, then hit+miss rise together.
      pulse_miss();
      repeat_step(RESPAWN_FRAMES, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) pulse_hit();
      repeat_step(2, 0, 1, 1, 0);
      repeat_step(2, 0, 0, 0, 0);

      // Reset mid-respawn with start held; start must be toggled to play.
      repeat_step(5, 0, 0, 0, 1);
      repeat_step(2, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0);
      repeat_step(5, 1, 0, 0, 0);
      repeat_step(2, 0, 0, 0, 0);
      pulse_start();

      // Random play.
      s = 0; h = 0; m = 0;
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 5) == 0)   h = ~h;
         if ($urandom_range(0, 11) == 0)  m = ~m;
         if ($urandom_range(0, 29) == 0)  s = ~s;
         step(($urandom_range(0, 1999) == 0), s, h, m, ($urandom_range(0, 2) == 0));
      end
      repeat_step(3, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
